// File: rtl/lsu_master_pkg.sv
`default_nettype none
// =============================================================================
// Module      : lsu_master_pkg
// Description : Access-size encoding, LSU state encoding and lane masks.
// Revision    : 1.0 - initial release
// =============================================================================
package lsu_master_pkg;

    typedef enum logic [1:0] {
        RW_BYTE    = 2'b00,
        RW_HALF    = 2'b01,
        RW_WORD    = 2'b10,
        RW_INVALID = 2'b11
    } rw_type_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    localparam logic [3:0] c_LANE_BYTE = 4'b0001;
    localparam logic [3:0] c_LANE_HALF = 4'b0011;
    localparam logic [3:0] c_LANE_WORD = 4'b1111;

    function automatic logic [3:0] lane_mask(input rw_type_t t);
        case (t)
            RW_BYTE: lane_mask = c_LANE_BYTE;
            RW_HALF: lane_mask = c_LANE_HALF;
            RW_WORD: lane_mask = c_LANE_WORD;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_master_mem_lane_align.sv
`default_nettype none
// =============================================================================
// Module      : mem_lane_align
// Description : Lane placement of store beats and merge/extension of load beats.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_lane_align
    import lsu_master_pkg::*;
(
    input  rw_type_t    req_type,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [7:0]  w_lanes;
    logic [4:0]  w_shift;
    logic [63:0] w_wr_wide;
    logic [63:0] w_rd_wide;
    logic [31:0] w_raw;

    // Shifting through a double-width vector yields both beats at once: the
    // upper half is exactly what spills into the next word.
    always_comb begin
        w_lanes   = {4'b0000, lane_mask(req_type)} << offset;
        w_shift   = {offset, 3'b000};
        w_wr_wide = {32'h0, wdata} << w_shift;
        split     = |w_lanes[7:4];
        be0       = w_lanes[3:0];
        be1       = w_lanes[7:4];
        wdata0    = w_wr_wide[31:0];
        wdata1    = w_wr_wide[63:32];
        w_rd_wide = {(split ? rdata1 : 32'h0), rdata0} >> w_shift;
        w_raw     = w_rd_wide[31:0];
        case (req_type)
            RW_BYTE: load_data = {{24{sign_ext & w_raw[7]}}, w_raw[7:0]};
            RW_HALF: load_data = {{16{sign_ext & w_raw[15]}}, w_raw[15:0]};
            default: load_data = w_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_master.sv
`default_nettype none
// =============================================================================
// Module      : lsu_master
// Description : Load/store initiator issuing one or two aligned memory beats.
// Revision    : 1.0 - initial release
// =============================================================================
module lsu_master
    import lsu_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  rw_type_t    req_type,
    input  logic        req_sign_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic        r_alive;
    logic        r_we;
    rw_type_t    r_type;
    logic        r_sign_ext;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_accept;
    logic        w_split;
    logic [3:0]  w_be0;
    logic [3:0]  w_be1;
    logic [31:0] w_wdata0;
    logic [31:0] w_wdata1;
    logic [31:0] w_load_data;
    logic [31:0] w_base;

    mem_lane_align u_align (
        .req_type  (r_type),
        .offset    (r_addr[1:0]),
        .sign_ext  (r_sign_ext),
        .wdata     (r_wdata),
        .rdata0    (r_rdata0),
        .rdata1    (r_rdata1),
        .split     (w_split),
        .be0       (w_be0),
        .be1       (w_be1),
        .wdata0    (w_wdata0),
        .wdata1    (w_wdata1),
        .load_data (w_load_data)
    );

    // r_alive holds req_ready low until the first edge after reset release.
    assign w_accept = (r_state == ST_IDLE) && r_alive && req_valid;
    assign w_base   = {r_addr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_type     <= RW_BYTE;
            r_sign_ext <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata0   <= 32'h0;
            r_rdata1   <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_type     <= req_type;
                r_sign_ext <= req_sign_ext;
                r_err      <= (req_type == RW_INVALID);
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (r_state == ST_WAIT0 && mem_rvalid) r_rdata0 <= mem_rdata;
            if (r_state == ST_WAIT1 && mem_rvalid) r_rdata1 <= mem_rdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)
                           w_state_next = (req_type == RW_INVALID) ? ST_RESP : ST_ISSUE0;
            ST_ISSUE0: if (mem_ready)  w_state_next = ST_WAIT0;
            ST_WAIT0:  if (mem_rvalid) w_state_next = w_split ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (mem_ready)  w_state_next = ST_WAIT1;
            ST_WAIT1:  if (mem_rvalid) w_state_next = ST_RESP;
            ST_RESP:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Beat fields are forced to zero outside the issue states.
    always_comb begin
        req_ready  = (r_state == ST_IDLE) && r_alive;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'h0;
        mem_be     = 4'h0;
        mem_wdata  = 32'h0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        case (r_state)
            ST_ISSUE0: begin
                mem_valid = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_base;
                mem_be    = w_be0;
                mem_wdata = w_wdata0;
            end
            ST_ISSUE1: begin
                mem_valid = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_base + 32'd4;
                mem_be    = w_be1;
                mem_wdata = w_wdata1;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = (r_we || r_err) ? 32'h0 : w_load_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_master.sv
`default_nettype none
// =============================================================================
// Module      : tb_lsu_master
// Description : Vector table, corner sequences and random traffic vs byte model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_lsu_master;
    import lsu_master_pkg::*;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_sign_ext;
    rw_type_t    req_type;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_sign_ext(req_sign_ext),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // ---------------- word memory (responder side) ----------------
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;
    beat_t beats[$];
    logic [31:0] wmem [logic [31:0]];
    logic [7:0]  rmem [logic [31:0]];
    int   stall_cnt = 0;
    int   stable_err = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : init_word(a);
    endfunction

    task automatic preload_word(input logic [31:0] a, input logic [31:0] v);
        wmem[a] = v;
        for (int i = 0; i < 4; i++) rmem[a + i] = v[8*i +: 8];
    endtask

    initial begin : responder
        logic        pending;
        logic [31:0] pend_data, w;
        logic        held_v;
        logic [31:0] h_addr, h_wdata;
        logic [3:0]  h_be;
        pending = 0; held_v = 0; pend_data = 0;
        h_addr = 0; h_wdata = 0; h_be = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_rvalid = 0;
            if (!rst_n) begin
                pending = 0; held_v = 0; mem_ready = 0;
                continue;
            end
            if (pending) begin
                mem_rvalid = 1; mem_rdata = pend_data; pending = 0;
            end
            if (mem_valid && stall_cnt > 0) begin
                mem_ready = 0; stall_cnt--;
            end else mem_ready = 1;
            if (mem_valid && held_v &&
                (mem_addr != h_addr || mem_be != h_be || mem_wdata != h_wdata))
                stable_err++;
            if (mem_valid && !mem_ready) begin
                held_v = 1; h_addr = mem_addr; h_be = mem_be; h_wdata = mem_wdata;
            end else held_v = 0;
            if (mem_valid && mem_ready) begin
                beats.push_back('{mem_we, mem_addr, mem_be, mem_wdata});
                w = mem_word(mem_addr);
                if (mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    wmem[mem_addr] = w;
                    pend_data = 32'h0;
                end else pend_data = w;
                pending = 1;
            end
        end
    end

    // ---------------- byte-level reference model ----------------
    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (rmem.exists(a)) return rmem[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic ref_apply(input logic we, input logic [1:0] typ, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                             output logic [31:0] rd, output logic err, output int nb, output int lat);
        int size;
        rd = 0; err = 0; nb = 0;
        size = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
        if (typ == 2'd3) err = 1;
        else begin
            nb = (int'(addr[1:0]) + size > 4) ? 2 : 1;
            for (int i = 0; i < size; i++) begin
                if (we) rmem[addr + i] = wdata[8*i +: 8];
                else    rd[8*i +: 8] = ref_byte(addr + i);
            end
            if (!we && sext && size < 4 && rd[8*size-1])
                for (int i = 8*size; i < 32; i++) rd[i] = 1'b1;
        end
        lat = 1 + 2*nb + ((nb > 0) ? stall : 0);
    endtask

    // ---------------- transaction driver ----------------
    task automatic run_txn(input logic we, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                           output logic [31:0] rd, output logic err, output int lat);
        int t0, k;
        logic got;
        rd = 0; err = 0; lat = -1; got = 0;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        beats.delete();
        stall_cnt = stall;
        req_valid = 1; req_we = we; req_type = rw_type_t'(typ);
        req_sign_ext = sext; req_addr = addr; req_wdata = wdata;
        t0 = cyc;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (i == 0) req_valid = 0;
            if (resp_valid) begin
                got = 1; rd = resp_rdata; err = resp_err; lat = cyc - t0;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic we; logic [1:0] typ; logic sext; logic [31:0] addr, wdata; int stall;
        logic [31:0] rd; logic err; int nb;
        logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0;
        logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1; int lat;
    } vec_t;
    vec_t tbl[11];

    initial begin : main
        logic [31:0] rd, erd;
        logic        err, eerr, saw;
        int          lat, elat, enb;
        logic        we, sext;
        logic [1:0]  typ;
        logic [31:0] addr, wdata;
        int          stall;

        tbl[0]  = '{1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 3};
        tbl[1]  = '{0, 2'd0, 1, 32'h303, 32'h0, 0, 32'hFFFFFF80, 0, 1, 32'h300, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 3};
        tbl[2]  = '{0, 2'd0, 0, 32'h303, 32'h0, 0, 32'h00000080, 0, 1, 32'h300, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 3};
        tbl[3]  = '{1, 2'd1, 0, 32'h107, 32'h1234, 0, 32'h0, 0, 2, 32'h104, 4'h8, 32'h34000000, 32'h108, 4'h1, 32'h00000012, 5};
        tbl[4]  = '{0, 2'd2, 0, 32'h201, 32'h0, 0, 32'h55443322, 0, 2, 32'h200, 4'hE, 32'h0, 32'h204, 4'h1, 32'h0, 5};
        tbl[5]  = '{0, 2'd1, 1, 32'h107, 32'h0, 0, 32'h00001234, 0, 2, 32'h104, 4'h8, 32'h0, 32'h108, 4'h1, 32'h0, 5};
        tbl[6]  = '{0, 2'd1, 1, 32'h302, 32'h0, 0, 32'hFFFF8011, 0, 1, 32'h300, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 3};
        tbl[7]  = '{1, 2'd2, 0, 32'hFFFFFFFD, 32'hAABBCCDD, 0, 32'h0, 0, 2, 32'hFFFFFFFC, 4'hE, 32'hBBCCDD00, 32'h0, 4'h1, 32'h000000AA, 5};
        tbl[8]  = '{0, 2'd3, 0, 32'h100, 32'h0, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
        tbl[9]  = '{0, 2'd2, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 6};
        tbl[10] = '{0, 2'd0, 0, 32'h000, 32'h0, 0, 32'h000000AA, 0, 1, 32'h000, 4'h1, 32'h0, 32'h0, 4'h0, 32'h0, 3};

        rst_n = 0; req_valid = 0; req_we = 0; req_type = RW_BYTE;
        req_sign_ext = 0; req_addr = 0; req_wdata = 0;
        preload_word(32'h300, 32'h80112233);
        preload_word(32'h200, 32'h44332211);
        preload_word(32'h204, 32'h88776655);

        // Reset values, then ready on the first cycle after release.
        repeat (2) @(negedge clk);
        check("rst_ctrl", {27'h0, req_ready, mem_valid, mem_we, resp_valid, resp_err}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_be_wdata", mem_wdata | {28'h0, mem_be}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        rst_n = 1;
        #1 check("ready_at_release", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("ready_after_release", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 11; i++) begin
            ref_apply(tbl[i].we, tbl[i].typ, tbl[i].sext, tbl[i].addr, tbl[i].wdata,
                      tbl[i].stall, erd, eerr, enb, elat);
            run_txn(tbl[i].we, tbl[i].typ, tbl[i].sext, tbl[i].addr, tbl[i].wdata,
                    tbl[i].stall, rd, err, lat);
            check($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tbl[i].err});
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_nbeats", i), beats.size(), tbl[i].nb);
            if (beats.size() > 0) begin
                check($sformatf("v%0d_b0_addr", i), beats[0].addr, tbl[i].a0);
                check($sformatf("v%0d_b0_be", i), {28'h0, beats[0].be}, {28'h0, tbl[i].be0});
                check($sformatf("v%0d_b0_wdata", i), beats[0].wdata, tbl[i].wd0);
                check($sformatf("v%0d_b0_we", i), {31'h0, beats[0].we}, {31'h0, tbl[i].we});
            end
            if (beats.size() > 1) begin
                check($sformatf("v%0d_b1_addr", i), beats[1].addr, tbl[i].a1);
                check($sformatf("v%0d_b1_be", i), {28'h0, beats[1].be}, {28'h0, tbl[i].be1});
                check($sformatf("v%0d_b1_wdata", i), beats[1].wdata, tbl[i].wd1);
            end
        end
        check("stall_beat_stable", stable_err, 0);

        // Reset while waiting on the second beat of a split load.
        @(negedge clk);
        beats.delete();
        req_valid = 1; req_we = 0; req_type = RW_WORD; req_sign_ext = 0;
        req_addr = 32'h201; req_wdata = 0;
        @(negedge clk);
        req_valid = 0;
        for (int i = 0; i < 20 && beats.size() < 2; i++) @(negedge clk);
        check("wait1_reached", beats.size(), 2);
        @(posedge clk);
        #1 rst_n = 0;
        #1 check("abort_ctrl", {27'h0, req_ready, mem_valid, mem_we, resp_valid, resp_err}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        saw = 0;
        repeat (2) begin @(negedge clk); saw |= resp_valid; end
        rst_n = 1;
        repeat (6) begin @(negedge clk); saw |= resp_valid; end
        check("abort_no_resp", {31'h0, saw}, 32'h0);
        ref_apply(1, 2'd2, 0, 32'h420, 32'h01020304, 0, erd, eerr, enb, elat);
        run_txn(1, 2'd2, 0, 32'h420, 32'h01020304, 0, rd, err, lat);
        check("post_abort_latency", lat, 3);

        // Random traffic against the byte-level model.
        for (int n = 0; n < 80; n++) begin
            we    = $urandom_range(0, 1);
            typ   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sext  = $urandom_range(0, 1);
            addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                                : 32'h400 + $urandom_range(0, 63);
            wdata = $urandom;
            stall = $urandom_range(0, 2);
            ref_apply(we, typ, sext, addr, wdata, stall, erd, eerr, enb, elat);
            run_txn(we, typ, sext, addr, wdata, stall, rd, err, lat);
            check($sformatf("r%0d_rdata", n), rd, erd);
            check($sformatf("r%0d_err", n), {31'h0, err}, {31'h0, eerr});
            check($sformatf("r%0d_nbeats", n), beats.size(), enb);
            check($sformatf("r%0d_latency", n), lat, elat);
        end
        check("random_beat_stable", stable_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
